// File: rtl/fpu_ex_ctrl.sv
// fpu_ex_ctrl: multi-cycle execute controller for the single-precision FPU.
// Accepts one FP instruction at a time, holds its operands/control stable on
// the combinational FPU inputs for an op-dependent latency, then registers the
// FPU result into a one-cycle writeback slot. Raises stall while busy.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid / in_ready         decode handshake
//   in_dataA, in_dataB          source operands
//   in_fpuOp, in_func3,
//   in_Rs1_0, in_rd, in_toInt   op select, func3, unsigned-convert bit, dest, int-file dest
//   flush                       kill in-flight or incoming instruction
//   dataA, dataB, fpuOp,
//   func3, EX_Rs1_0             held values driving the FPU
//   fpuResult                   FPU output
//   stall                       in_valid & ~in_ready (combinational)
//   wb_valid, wb_data,
//   wb_rd, wb_toInt             writeback strobe and payload
module fpu_ex_ctrl #(
  parameter int unsigned width    = 32,
  parameter int unsigned LAT_ADD  = 3,
  parameter int unsigned LAT_MUL  = 3,
  parameter int unsigned LAT_DIV  = 12,
  parameter int unsigned LAT_SQRT = 14,
  parameter int unsigned LAT_MISC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_dataA,
  input  logic [width-1:0] in_dataB,
  input  logic [3:0]       in_fpuOp,
  input  logic [2:0]       in_func3,
  input  logic             in_Rs1_0,
  input  logic [4:0]       in_rd,
  input  logic             in_toInt,
  input  logic             flush,
  output logic [width-1:0] dataA,
  output logic [width-1:0] dataB,
  output logic [3:0]       fpuOp,
  output logic [2:0]       func3,
  output logic             EX_Rs1_0,
  input  logic [width-1:0] fpuResult,
  output logic             stall,
  output logic             wb_valid,
  output logic [width-1:0] wb_data,
  output logic [4:0]       wb_rd,
  output logic             wb_toInt
);

  localparam int unsigned MAX_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int unsigned MAX_DS  = (LAT_DIV > LAT_SQRT) ? LAT_DIV : LAT_SQRT;
  localparam int unsigned MAX_4   = (MAX_AM > MAX_DS) ? MAX_AM : MAX_DS;
  localparam int unsigned LAT_MAX = (MAX_4 > LAT_MISC) ? MAX_4 : LAT_MISC;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               accept_c;
  logic               capture_c;
  logic [4:0]         rd_q;
  logic               to_int_q;
  logic               undef_op_c;

  // Latency minus one for the counter preload
  function automatic logic [CNT_W-1:0] lat_m1(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001: return CNT_W'(LAT_ADD - 1);
      4'b0010:          return CNT_W'(LAT_MUL - 1);
      4'b0011:          return CNT_W'(LAT_DIV - 1);
      4'b0110:          return CNT_W'(LAT_SQRT - 1);
      default:          return CNT_W'(LAT_MISC - 1);
    endcase
  endfunction

  assign accept_c   = in_valid & in_ready & ~flush;
  assign stall      = in_valid & ~in_ready;
  // Codes 1010..1111 have no FPU function; their result is forced to zero
  assign undef_op_c = fpuOp[3] & (fpuOp[2] | fpuOp[1]);

  // Next-state and counter logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture_c = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          state_nxt = BUSY;
          cnt_nxt   = lat_m1(in_fpuOp);
        end
      end
      BUSY: begin
        // Flush wins over completion on the final busy cycle
        if (flush) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          capture_c = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        if (accept_c) begin
          state_nxt = BUSY;
          cnt_nxt   = lat_m1(in_fpuOp);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, holding and writeback registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      in_ready <= 1'b1;
      dataA    <= '0;
      dataB    <= '0;
      fpuOp    <= '0;
      func3    <= '0;
      EX_Rs1_0 <= 1'b0;
      rd_q     <= '0;
      to_int_q <= 1'b0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      wb_toInt <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      in_ready <= (state_nxt != BUSY);
      wb_valid <= capture_c;
      if (accept_c) begin
        dataA    <= in_dataA;
        dataB    <= in_dataB;
        fpuOp    <= in_fpuOp;
        func3    <= in_func3;
        EX_Rs1_0 <= in_Rs1_0;
        rd_q     <= in_rd;
        to_int_q <= in_toInt;
      end
      if (capture_c) begin
        wb_data  <= undef_op_c ? '0 : fpuResult;
        wb_rd    <= rd_q;
        wb_toInt <= to_int_q;
      end
    end
  end

endmodule

// File: tb/tb_fpu_ex_ctrl.sv
// tb_fpu_ex_ctrl: directed self-checking bench for fpu_ex_ctrl. A small
// table-driven FPU stand-in answers only the operand patterns used here, so a
// result captured from the wrong operands or at the wrong time shows up.
module tb_fpu_ex_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_dataA, in_dataB;
  logic [3:0]  in_fpuOp;
  logic [2:0]  in_func3;
  logic        in_Rs1_0;
  logic [4:0]  in_rd;
  logic        in_toInt;
  logic        flush;
  logic [31:0] dataA, dataB;
  logic [3:0]  fpuOp;
  logic [2:0]  func3;
  logic        EX_Rs1_0;
  logic [31:0] fpu_result;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_toInt;

  int n_checks = 0;
  int n_pass   = 0;

  fpu_ex_ctrl dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dataA(in_dataA), .in_dataB(in_dataB),
    .in_fpuOp(in_fpuOp), .in_func3(in_func3), .in_Rs1_0(in_Rs1_0),
    .in_rd(in_rd), .in_toInt(in_toInt), .flush(flush),
    .dataA(dataA), .dataB(dataB), .fpuOp(fpuOp), .func3(func3),
    .EX_Rs1_0(EX_Rs1_0), .fpuResult(fpu_result), .stall(stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_toInt(wb_toInt)
  );

  always #5 clk = ~clk;

  // FPU stand-in: known answers for the vectors below, garbage otherwise
  always_comb begin
    fpu_result = 32'hDEAD_BEEF;
    case (fpuOp)
      4'b0000: if (dataA == 32'h3F80_0000 && dataB == 32'h4000_0000) fpu_result = 32'h4040_0000;
      4'b0010: if (dataA == 32'h4040_0000 && dataB == 32'h4000_0000) fpu_result = 32'h40C0_0000;
      4'b0011: if (dataA == 32'h40C0_0000 && dataB == 32'h4000_0000) fpu_result = 32'h4040_0000;
      4'b0110: if (dataA == 32'h4180_0000) fpu_result = 32'h4080_0000;
      4'b0111: if (func3 == 3'b000 && dataA == 32'h3F80_0000 && dataB == 32'h4000_0000) fpu_result = 32'h0000_0001;
      default: fpu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic ti);
    in_valid = 1'b1;
    in_fpuOp = op;
    in_func3 = f3;
    in_dataA = a;
    in_dataB = b;
    in_rd    = rd;
    in_toInt = ti;
    in_Rs1_0 = 1'b0;
  endtask

  // Issue one op in the current cycle, hold in_valid, and check the whole timeline
  task automatic run_op(input string tag, input logic [3:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic ti, input int lat, input logic [31:0] exp);
    drive(op, f3, a, b, rd, ti);
    #1;
    check({tag, "_stall_accept"}, 32'(stall), 32'd0);
    for (int i = 1; i <= lat; i++) begin
      tick();
      check({tag, "_stall_busy"}, 32'(stall), 32'd1);
      check({tag, "_wbv_busy"}, 32'(wb_valid), 32'd0);
    end
    tick();
    check({tag, "_wbv_done"}, 32'(wb_valid), 32'd1);
    check({tag, "_wb_data"}, wb_data, exp);
    check({tag, "_wb_rd"}, 32'(wb_rd), 32'(rd));
    check({tag, "_wb_toint"}, 32'(wb_toInt), 32'(ti));
    in_valid = 1'b0;
    tick();
    check({tag, "_wbv_after"}, 32'(wb_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  // Step n cycles and confirm no writeback strobe appears
  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (wb_valid) seen = 1'b1;
    end
    check({tag, "_no_wb"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    in_dataA = '0; in_dataB = '0; in_fpuOp = '0; in_func3 = '0;
    in_Rs1_0 = 1'b0; in_rd = '0; in_toInt = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      check("idle_ready", 32'(in_ready), 32'd1);
      check("idle_wbv", 32'(wb_valid), 32'd0);
      check("idle_wbdata", wb_data, 32'd0);
      check("idle_stall", 32'(stall), 32'd0);
      tick();
    end

    // FADD 1.0 + 2.0 = 3.0
    run_op("fadd", 4'b0000, 3'b000, 32'h3F80_0000, 32'h4000_0000, 5'd7, 1'b0, 3, 32'h4040_0000);

    // FDIV 6.0 / 2.0 then FMUL 3.0 * 2.0 queued behind it
    drive(4'b0011, 3'b000, 32'h40C0_0000, 32'h4000_0000, 5'd9, 1'b0);
    tick();
    drive(4'b0010, 3'b000, 32'h4040_0000, 32'h4000_0000, 5'd11, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      check("fdiv_stall", 32'(stall), 32'd1);
      check("fdiv_held_a", dataA, 32'h40C0_0000);
      check("fdiv_wbv_busy", 32'(wb_valid), 32'd0);
      if (i < 12) tick();
    end
    tick();
    check("fdiv_wbv", 32'(wb_valid), 32'd1);
    check("fdiv_data", wb_data, 32'h4040_0000);
    check("fdiv_rd", 32'(wb_rd), 32'd9);
    check("fdiv_done_stall", 32'(stall), 32'd0);
    tick();
    in_valid = 1'b0;
    check("fmul_busy_ready", 32'(in_ready), 32'd0);
    check("fmul_held_op", 32'(fpuOp), 32'd2);
    tick(); tick();
    check("fmul_wbv_busy", 32'(wb_valid), 32'd0);
    tick();
    check("fmul_wbv", 32'(wb_valid), 32'd1);
    check("fmul_data", wb_data, 32'h40C0_0000);
    check("fmul_rd", 32'(wb_rd), 32'd11);
    tick();
    check("fmul_wbv_after", 32'(wb_valid), 32'd0);

    // Flush at cycle k+6 of an FDIV
    drive(4'b0011, 3'b000, 32'h40C0_0000, 32'h4000_0000, 5'd3, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 2; i <= 6; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle_ready", 32'(in_ready), 32'd1);
    check("flush_wbv", 32'(wb_valid), 32'd0);
    quiet("flush", 14);
    run_op("fadd2", 4'b0000, 3'b000, 32'h3F80_0000, 32'h4000_0000, 5'd12, 1'b0, 3, 32'h4040_0000);

    // Flush on the final busy cycle beats completion
    drive(4'b0000, 3'b000, 32'h3F80_0000, 32'h4000_0000, 5'd4, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_last_wbv", 32'(wb_valid), 32'd0);
    check("flush_last_ready", 32'(in_ready), 32'd1);
    quiet("flush_last", 4);

    // FLE 1.0 <= 2.0 to the integer file
    run_op("fle", 4'b0111, 3'b000, 32'h3F80_0000, 32'h4000_0000, 5'd5, 1'b1, 1, 32'h0000_0001);

    // Undefined op forces zero result
    run_op("undef", 4'b1100, 3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 5'd30, 1'b0, 1, 32'h0000_0000);

    // Reset during a busy FSQRT
    drive(4'b0110, 3'b000, 32'h4180_0000, 32'h0000_0000, 5'd6, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_busy_ready", 32'(in_ready), 32'd1);
    check("rst_busy_wbv", 32'(wb_valid), 32'd0);
    check("rst_busy_wbdata", wb_data, 32'd0);
    check("rst_busy_dataA", dataA, 32'd0);
    quiet("rst_busy", 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_ex_ctrl.md
# fpu_ex_ctrl

Multi-cycle execute controller for the single-precision FPU. Sits directly upstream of the combinational FPU datapath: accepts one FP instruction at a time from decode, holds the operands and control stable on the FPU inputs for an op-dependent number of cycles, then registers the FPU result into a writeback slot. It also generates the pipeline stall while an operation is in flight.

## Interface
- `width`, 32, operand/result width.
- `LAT_ADD`, 3, cycles for FADD/FSUB (fpuOp 0000/0001).
- `LAT_MUL`, 3, cycles for FMUL (0010).
- `LAT_DIV`, 12, cycles for FDIV (0011).
- `LAT_SQRT`, 14, cycles for FSQRT (0110).
- `LAT_MISC`, 1, cycles for all other fpuOp codes; every LAT_* ≥ 1.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: decode presents an FP instruction.
- `in_ready` out 1: controller can accept this cycle.
- `in_dataA`, `in_dataB` in width: source operands.
- `in_fpuOp` in 4, `in_func3` in 3, `in_Rs1_0` in 1: FPU op select, func3, rs2-field bit 0 (unsigned convert).
- `in_rd` in 5: destination register.
- `in_toInt` in 1: destination is the integer file (compares, FCVT.W[U].S).
- `flush` in 1: kill in-flight/incoming instruction.
- `dataA`, `dataB` out width; `fpuOp` out 4; `func3` out 3; `EX_Rs1_0` out 1: held values driving the FPU.
- `fpuResult` in width: FPU output.
- `stall` out 1: `in_valid & ~in_ready`.
- `wb_valid` out 1: one-cycle result strobe.
- `wb_data` out width, `wb_rd` out 5, `wb_toInt` out 1: writeback payload, valid with `wb_valid`.

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE; all outputs 0 except `in_ready` = 1.
- `in_ready` = 1 in IDLE and DONE, 0 in BUSY.
- Accept = `in_valid & in_ready & ~flush`. On accept, register operands, op, func3, Rs1_0, rd, toInt into the holding registers (these drive the FPU outputs). Load `cnt` = L−1, where L is the LAT_* value for `in_fpuOp`. Go to BUSY.
- BUSY: if `flush`, go to IDLE with no writeback. Else if `cnt` = 0, register `fpuResult` into `wb_data` and the held rd/toInt into `wb_rd`/`wb_toInt`, then go to DONE. Else decrement `cnt`.
- DONE: `wb_valid` = 1 for exactly this cycle. On accept → BUSY, else → IDLE.
- Flush in DONE: the current `wb_valid` still commits; a same-cycle accept is blocked; next state is IDLE.
- Undefined fpuOp (1010–1111) uses LAT_MISC. `wb_data` = 0 because the FPU leaves its result undefined and the controller forces 0.
- Holding registers retain their last value in IDLE/DONE; they change only on accept.
- `cnt` width = clog2(max LAT)+1; no wrap, since it is reloaded on every accept.

## Timing
- Accept at edge k → BUSY during cycles k+1 … k+L. Result is captured at edge k+L+1. `wb_valid` is high in cycle k+L+1, so total latency is L+1 cycles from the accept edge.
- Back-to-back: a new accept in a DONE cycle starts BUSY the next cycle, giving one op per L+1 cycles at steady state.
- `stall` is combinational and is high throughout BUSY whenever `in_valid` = 1.
- Reset mid-BUSY: IDLE next cycle, `wb_valid` 0, `wb_data` 0, no writeback.
- Flush has priority over completion in the same BUSY cycle where `cnt` = 0.

## Test plan
- Reset then idle: `in_ready` = 1, `wb_valid` = 0, `wb_data` = 0, `stall` = 0 for 5 cycles.
- FADD 0x3F800000 + 0x40000000 accepted at edge k: `stall` high in cycles k+1..k+3 with `in_valid` held. `wb_valid` high only in cycle k+4 with `wb_data` = 0x40400000 and `wb_rd` as given.
- FDIV 0x40C00000 / 0x40000000 then immediate FMUL queued: FDIV writes back 0x40400000 at k+13. FMUL is accepted in that DONE cycle and writes back at k+13+4.
- Flush at cycle k+6 of an FDIV: IDLE at k+7, no `wb_valid` ever for that op, and the next FADD completes normally.
- FLE (fpuOp 0111, func3 000) of 1.0 ≤ 2.0 with `in_toInt` = 1: `wb_valid` at k+2, `wb_data` = 1, `wb_toInt` = 1.
- fpuOp 1100: `wb_valid` at k+2 with `wb_data` = 0. `reset` asserted during a BUSY FSQRT returns to IDLE with no writeback.
